frame_tiler: RTL and testbench
==============================

// Module: frame_tiler
// PURPOSE
//   Walks a frame of frame_H x frame_W pixels and emits one tile descriptor per cycle,
//   in row-major order: origin (row, col) and extent (rows, cols), with edge tiles clipped.
//   Sits between the frame-level controller and the tile DMA / compute scheduler.
//   A start pulse runs one frame; a done pulse marks the end of the frame.
// PARAMETERS
//   WIDTH  16  bit width of all dimensions, indices and extents
// PORTS
//   clk            in   1      single clock; everything acts on the rising edge
//   rst            in   1      synchronous reset, active-high
//   start          in   1      one-cycle pulse; latches config and begins a frame (honoured only in IDLE)
//   frame_H        in   WIDTH  frame height in pixels
//   frame_W        in   WIDTH  frame width in pixels
//   tile_rows      in   WIDTH  nominal tile height
//   tile_cols_max  in   WIDTH  nominal (maximum) tile width
//   tile_valid     out  1      descriptor outputs valid this cycle
//   tile_row_idx   out  WIDTH  pixel row of tile origin
//   tile_col_idx   out  WIDTH  pixel column of tile origin
//   tile_rows_out  out  WIDTH  tile height = min(tile_rows, frame_H - tile_row_idx)
//   tile_cols_out  out  WIDTH  tile width = min(tile_cols_max, frame_W - tile_col_idx)
//   done           out  1      one-cycle pulse after the last tile of the frame
// BEHAVIOUR
//   - All outputs are registered. On rst every output is 0 and the FSM is in IDLE.
//     rst overrides everything, including a frame in progress; the frame is abandoned.
//   - FSM states: IDLE, EMIT, FINISH.
//     IDLE -> EMIT: start=1 and all four config inputs are non-zero.
//     IDLE -> FINISH: start=1 and any config input is 0; the frame emits zero tiles.
//     EMIT -> FINISH: after the last tile is issued.
//     FINISH -> IDLE: unconditionally, after one cycle.
//   - Config is latched on the accepted start edge. Input changes after that are ignored
//     until the next frame.
//   - Latency: first tile_valid is in the cycle right after the start edge. No stalls:
//     one tile per cycle, tile_valid held high continuously in EMIT.
//   - Tile order is row-major. col_idx advances by tile_cols_max; when col_idx+tile_cols_max
//     >= W, col_idx wraps to 0 and row_idx advances by tile_rows. The last tile is the one
//     where both the row and column advance would reach the frame bound.
//   - Tile count = ceil(H/tile_rows) * ceil(W/tile_cols_max).
//   - done is high for exactly one cycle, in FINISH. That cycle is the one after the last
//     tile_valid cycle, or the cycle after start for an empty frame. tile_valid=0 during done.
//   - Invariants: tile_row_idx+tile_rows_out <= H; tile_col_idx+tile_cols_out <= W;
//     every extent is >= 1.
//   - Arithmetic: compute idx+step in WIDTH+1 bits so that a sum near 2^WIDTH never wraps.
//     Extents are clipped by subtraction, never by modulo.
//   - start while in EMIT or FINISH is ignored; it is neither queued nor a restart.
//   - When tile_valid=0, the index and extent outputs hold their last values.
//     They read 0 after reset.
// STRUCTURE
//   - Shared package: FSM state enum (IDLE/EMIT/FINISH) and the WIDTH default constant.
//   - One natural sub-module: tile_extent_clip (pos, step, limit -> min(step, limit-pos),
//     last flag), instantiated once for rows and once for columns.
//   - Top level holds the FSM, latched config, and the row/col counters.
// TESTING
//   - H=10,W=14,tr=4,tc=5: 9 tiles.
//     Origins (0,0)(0,5)(0,10)(4,0)..(8,10).
//     Last tile extent 2x4. done one cycle after the (8,10) tile.
//   - H=8,W=8,tr=4,tc=4: exactly 4 tiles, all 4x4, issued back-to-back; done follows.
//   - H=3,W=3,tr=8,tc=8: one tile at (0,0) with extent 3x3, then done.
//   - H=0 (or tr=0): no tile_valid; done pulses in the cycle after start.
//   - start pulsed again mid-frame: ignored, still 9 tiles.
//     rst asserted mid-frame: all outputs 0 next cycle; a new start restarts from (0,0).
//   - Every scenario checks the bound invariants on each valid tile.
//     Tile count must equal ceil(H/tr)*ceil(W/tc).

Source files
------------

// File: rtl/frame_tiler_pkg.sv
// Shared definitions for the frame tiler: FSM state encoding and default dimension width.
package frame_tiler_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/frame_tiler_if.sv
// Frame tiler bus: frame configuration and start from the controller, tile descriptors back.
interface frame_tiler_if #(
    parameter int WIDTH = frame_tiler_pkg::WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] frame_H;
    logic [WIDTH-1:0] frame_W;
    logic [WIDTH-1:0] tile_rows;
    logic [WIDTH-1:0] tile_cols_max;
    logic             tile_valid;
    logic [WIDTH-1:0] tile_row_idx;
    logic [WIDTH-1:0] tile_col_idx;
    logic [WIDTH-1:0] tile_rows_out;
    logic [WIDTH-1:0] tile_cols_out;
    logic             done;

    // Controller side: owns the frame config and start pulse.
    modport master (
        output start, frame_H, frame_W, tile_rows, tile_cols_max,
        input  tile_valid, tile_row_idx, tile_col_idx, tile_rows_out, tile_cols_out, done
    );

    // Tiler side.
    modport slave (
        input  start, frame_H, frame_W, tile_rows, tile_cols_max,
        output tile_valid, tile_row_idx, tile_col_idx, tile_rows_out, tile_cols_out, done
    );

endinterface

// File: rtl/frame_tiler_tile_extent_clip.sv
// One-axis tile step: extent clipped to the frame edge, next origin, and whether this is the axis' last tile.
module tile_extent_clip
    import frame_tiler_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] pos,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] extent,
    output logic [WIDTH-1:0] next_pos,
    output logic             last
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] remaining;

    // One extra bit so an origin near 2^WIDTH plus a step cannot wrap below the limit.
    assign sum       = {1'b0, pos} + {1'b0, step};
    assign remaining = limit - pos;
    assign extent    = (step < remaining) ? step : remaining;
    assign next_pos  = sum[WIDTH-1:0];
    assign last      = (sum >= {1'b0, limit});

endmodule

// File: rtl/frame_tiler.sv
// Walks a frame in row-major order and issues one clipped tile descriptor per cycle.
module frame_tiler
    import frame_tiler_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    frame_tiler_if.slave tif
);

    state_t           state_q;
    logic [WIDTH-1:0] h_q, w_q, tr_q, tc_q;
    logic [WIDTH-1:0] row_q, col_q;
    logic             last_q;

    logic             tile_valid_q, done_q;
    logic [WIDTH-1:0] row_idx_q, col_idx_q, rows_out_q, cols_out_q;

    logic             idle_d, cfg_ok_d, issue_d;
    logic [WIDTH-1:0] row_pos_d, row_step_d, row_lim_d;
    logic [WIDTH-1:0] col_pos_d, col_step_d, col_lim_d;
    logic [WIDTH-1:0] row_ext_d, row_next_d, col_ext_d, col_next_d;
    logic             row_last_d, col_last_d;

    assign idle_d   = (state_q == ST_IDLE);
    assign cfg_ok_d = (tif.frame_H != '0) && (tif.frame_W != '0) &&
                      (tif.tile_rows != '0) && (tif.tile_cols_max != '0);
    assign issue_d  = (idle_d && tif.start && cfg_ok_d) ||
                      ((state_q == ST_EMIT) && !last_q);

    // In IDLE the first tile is computed straight from the live config so it is
    // registered on the start edge itself, giving zero-bubble latency.
    always_comb begin
        row_pos_d  = row_q;
        row_step_d = tr_q;
        row_lim_d  = h_q;
        col_pos_d  = col_q;
        col_step_d = tc_q;
        col_lim_d  = w_q;
        if (idle_d) begin
            row_pos_d  = '0;
            row_step_d = tif.tile_rows;
            row_lim_d  = tif.frame_H;
            col_pos_d  = '0;
            col_step_d = tif.tile_cols_max;
            col_lim_d  = tif.frame_W;
        end
    end

    tile_extent_clip #(.WIDTH(WIDTH)) u_row_clip (
        .pos      (row_pos_d),
        .step     (row_step_d),
        .limit    (row_lim_d),
        .extent   (row_ext_d),
        .next_pos (row_next_d),
        .last     (row_last_d)
    );

    tile_extent_clip #(.WIDTH(WIDTH)) u_col_clip (
        .pos      (col_pos_d),
        .step     (col_step_d),
        .limit    (col_lim_d),
        .extent   (col_ext_d),
        .next_pos (col_next_d),
        .last     (col_last_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            h_q          <= '0;
            w_q          <= '0;
            tr_q         <= '0;
            tc_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            last_q       <= 1'b0;
            tile_valid_q <= 1'b0;
            done_q       <= 1'b0;
            row_idx_q    <= '0;
            col_idx_q    <= '0;
            rows_out_q   <= '0;
            cols_out_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (tif.start) begin
                        if (cfg_ok_d) begin
                            h_q     <= tif.frame_H;
                            w_q     <= tif.frame_W;
                            tr_q    <= tif.tile_rows;
                            tc_q    <= tif.tile_cols_max;
                            state_q <= ST_EMIT;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_EMIT: begin
                    // last_q flags that the descriptor currently on the outputs ends the frame.
                    if (last_q) begin
                        tile_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    tile_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase

            if (issue_d) begin
                tile_valid_q <= 1'b1;
                row_idx_q    <= row_pos_d;
                col_idx_q    <= col_pos_d;
                rows_out_q   <= row_ext_d;
                cols_out_q   <= col_ext_d;
                last_q       <= row_last_d && col_last_d;
                if (col_last_d) begin
                    col_q <= '0;
                    row_q <= row_next_d;
                end else begin
                    col_q <= col_next_d;
                    row_q <= row_pos_d;
                end
            end
        end
    end

    assign tif.tile_valid    = tile_valid_q;
    assign tif.tile_row_idx  = row_idx_q;
    assign tif.tile_col_idx  = col_idx_q;
    assign tif.tile_rows_out = rows_out_q;
    assign tif.tile_cols_out = cols_out_q;
    assign tif.done          = done_q;

endmodule

// File: tb/tb_frame_tiler.sv
// Directed bench for frame_tiler: a reference walk fills a descriptor queue that a monitor drains.
module tb_frame_tiler;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] c;
        logic [W-1:0] nr;
        logic [W-1:0] nc;
    } tile_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    tile_t exp_q[$];
    tile_t got_t, exp_t, last_t;
    int    tests = 0;
    int    fails = 0;
    int    seen  = 0;
    int    cur_h = 0;
    int    cur_w = 0;

    always #5 clk = ~clk;

    frame_tiler_if #(.WIDTH(W)) tif ();

    frame_tiler #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int push_model(input int h, input int w, input int tr, input int tc);
        tile_t t;
        int    n = 0;
        if (h > 0 && w > 0 && tr > 0 && tc > 0) begin
            for (int r = 0; r < h; r += tr) begin
                for (int c = 0; c < w; c += tc) begin
                    t.r  = W'(r);
                    t.c  = W'(c);
                    t.nr = W'((tr < h - r) ? tr : h - r);
                    t.nc = W'((tc < w - c) ? tc : w - c);
                    exp_q.push_back(t);
                    n++;
                end
            end
        end
        return n;
    endfunction

    // Monitor: every valid descriptor is matched against the queue head and the frame bounds.
    always @(negedge clk) begin
        if (!rst && tif.tile_valid === 1'b1) begin
            got_t = {tif.tile_row_idx, tif.tile_col_idx, tif.tile_rows_out, tif.tile_cols_out};
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL extra_tile observed=%0h expected=none", got_t);
            end else begin
                exp_t = exp_q.pop_front();
                check("tile", 64'(got_t), 64'(exp_t));
                check("row_bound", 64'(int'(got_t.r) + int'(got_t.nr) <= cur_h), 64'd1);
                check("col_bound", 64'(int'(got_t.c) + int'(got_t.nc) <= cur_w), 64'd1);
                check("extent_nz", 64'(got_t.nr != 0 && got_t.nc != 0), 64'd1);
            end
            seen++;
        end
    end

    task automatic drive_cfg(input logic s, input int h, input int w, input int tr, input int tc);
        tif.start         = s;
        tif.frame_H       = W'(h);
        tif.frame_W       = W'(w);
        tif.tile_rows     = W'(tr);
        tif.tile_cols_max = W'(tc);
    endtask

    task automatic run_frame(input int h, input int w, input int tr, input int tc, input bit mid_start);
        int n_model;
        int n_exp;
        int cyc;
        exp_q.delete();
        seen    = 0;
        cur_h   = h;
        cur_w   = w;
        n_model = push_model(h, w, tr, tc);
        n_exp   = (h > 0 && w > 0 && tr > 0 && tc > 0) ?
                  ((h + tr - 1) / tr) * ((w + tc - 1) / tc) : 0;
        if (n_model > 0) last_t = exp_q[$];
        @(negedge clk);
        drive_cfg(1'b1, h, w, tr, tc);
        @(negedge clk);
        tif.start = 1'b0;
        cyc = 1;
        while (tif.done !== 1'b1 && cyc < 2000) begin
            if (mid_start && cyc == 3) drive_cfg(1'b1, 2, 2, 1, 1);
            else tif.start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        tif.start = 1'b0;
        $display("[TB] frame H=%0d W=%0d tr=%0d tc=%0d mid_start=%0d: %0d tiles, done at cycle %0d",
                 h, w, tr, tc, mid_start, seen, cyc);
        check("done_cycle", 64'(cyc), 64'(n_exp + 1));
        check("tile_count", 64'(seen), 64'(n_exp));
        check("valid_at_done", 64'(tif.tile_valid), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("done_width", 64'(tif.done), 64'd0);
        check("idle_valid", 64'(tif.tile_valid), 64'd0);
        if (n_model > 0)
            check("hold_outputs",
                  64'({tif.tile_row_idx, tif.tile_col_idx, tif.tile_rows_out, tif.tile_cols_out}),
                  64'(last_t));
    endtask

    initial begin
        int n_rst;
        drive_cfg(1'b0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(tif.tile_valid), 64'd0);
        check("rst_done", 64'(tif.done), 64'd0);
        check("rst_outputs",
              64'({tif.tile_row_idx, tif.tile_col_idx, tif.tile_rows_out, tif.tile_cols_out}), 64'd0);
        rst = 1'b0;

        run_frame(10, 14, 4, 5, 1'b0);
        run_frame(8, 8, 4, 4, 1'b0);
        run_frame(3, 3, 8, 8, 1'b0);
        run_frame(0, 14, 4, 5, 1'b0);
        run_frame(10, 14, 0, 5, 1'b0);
        run_frame(10, 14, 4, 5, 1'b1);
        run_frame(65535, 65530, 40000, 65000, 1'b0);

        // Abandon a frame with reset part-way through, then restart from the origin.
        exp_q.delete();
        seen  = 0;
        cur_h = 10;
        cur_w = 14;
        n_rst = push_model(10, 14, 4, 5);
        @(negedge clk);
        drive_cfg(1'b1, 10, 14, 4, 5);
        @(negedge clk);
        tif.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        $display("[TB] reset mid-frame after %0d of %0d tiles", seen, n_rst);
        check("midrst_valid", 64'(tif.tile_valid), 64'd0);
        check("midrst_done", 64'(tif.done), 64'd0);
        check("midrst_outputs",
              64'({tif.tile_row_idx, tif.tile_col_idx, tif.tile_rows_out, tif.tile_cols_out}), 64'd0);
        rst = 1'b0;
        run_frame(10, 14, 4, 5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
